// File: rtl/wb_master_pkg.sv
// Shared widths, FSM state encoding and command/response bundles for the
// wishbone pipelined master.
package wb_master_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int GRANULE    = 8;
  localparam int SEL_WIDTH  = DATA_WIDTH / GRANULE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
    logic [SEL_WIDTH-1:0]  sel;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic                  err;
    logic                  tmo;
  } rsp_t;

endpackage

// File: rtl/wb_master_core.sv
// Wishbone B4 pipelined initiator, one outstanding single-beat transfer.
// Define WB_TIMEOUT_EN to abort cycles that get no ack/err within TIMEOUT cycles.
module wb_master_core
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_tmo_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  stall_i
);

  state_t state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  logic   cyc_q, cyc_d;
  logic   stb_q, stb_d;
  logic   rsp_valid_q, rsp_valid_d;
  logic   cmd_ready_q, cmd_ready_d;
  logic   accept;

  assign accept = (state_q == IDLE) && cmd_valid_i && cmd_ready_q;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_hit;

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == REQ || state_q == WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Every output is a flop, so this block computes next values, not outputs.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    rsp_valid_d = rsp_valid_q;
    cmd_ready_d = cmd_ready_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_d.we    = cmd_we_i;
          cmd_d.adr   = cmd_adr_i;
          cmd_d.dat   = cmd_we_i ? cmd_dat_i : '0;
          cmd_d.sel   = cmd_sel_i;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
`ifdef WB_TIMEOUT_EN
        if (tmo_hit) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_d.dat   = '0;
          rsp_d.err   = 1'b1;
          rsp_d.tmo   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else
`endif
        if (!stall_i) begin
          stb_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // err wins over a simultaneous ack
        if (ack_i || err_i) begin
          rsp_d.dat   = (err_i || cmd_q.we) ? '0 : dat_i;
          rsp_d.err   = err_i;
          rsp_d.tmo   = 1'b0;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_hit) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_d.dat   = '0;
          rsp_d.err   = 1'b1;
          rsp_d.tmo   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
`endif
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_q.dat;
  assign rsp_err_o   = rsp_q.err;
  assign rsp_tmo_o   = rsp_q.tmo;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;
  assign we_o        = cmd_q.we;
  assign adr_o       = cmd_q.adr;
  assign dat_o       = cmd_q.dat;
  assign sel_o       = cmd_q.sel;

endmodule

// File: tb/tb_wb_master_core.sv
// Directed bench for wb_master_core with a negedge-driven wishbone slave model.
// Build with WB_TIMEOUT_EN to also exercise the timeout abort (TIMEOUT=8).
module tb_wb_master_core;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [15:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o, rsp_tmo_o;
  logic        cyc_o, stb_o, we_o;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i, err_i, stall_i;

  int checks = 0;
  int errors = 0;

  // slave model knobs: 0=ack, 1=err, 2=ack+err, 3=never respond
  int          stall_left = 0;
  int          resp_mode  = 0;
  logic [31:0] rd_data    = '0;
  logic        pending    = 1'b0;
  logic        stray_ack  = 1'b0;

  int          stb_cnt, cyc_cnt, unstable_cnt;
  logic [15:0] mon_adr;
  logic [31:0] mon_dat;
  logic [3:0]  mon_sel;

  wb_master_core #(.TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .stall_i(stall_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave: stalls stb for stall_left cycles, then answers in the following cycle.
  always @(negedge clk_i) begin
    dat_i = rd_data;
    if (rst_i) begin
      stall_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; pending = 1'b0;
    end else if (cyc_o && stb_o) begin
      ack_i = 1'b0; err_i = 1'b0;
      if (stall_left > 0) begin
        stall_i = 1'b1;
        stall_left--;
      end else begin
        stall_i = 1'b0;
        pending = 1'b1;
      end
    end else if (pending) begin
      stall_i = 1'b0;
      pending = 1'b0;
      ack_i   = (resp_mode == 0 || resp_mode == 2);
      err_i   = (resp_mode == 1 || resp_mode == 2);
    end else begin
      stall_i = 1'b0;
      ack_i   = stray_ack;
      err_i   = stray_ack;
    end
  end

  always @(negedge clk_i) begin
    if (stb_o) begin
      stb_cnt++;
      if (adr_o != mon_adr || dat_o != mon_dat || sel_o != mon_sel) unstable_cnt++;
    end
    if (cyc_o) cyc_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel,
                               input int limit, output int lat);
    int n;
    @(negedge clk_i);
    stb_cnt = 0; cyc_cnt = 0; unstable_cnt = 0;
    mon_adr = adr; mon_dat = we ? dat : 32'h0; mon_sel = sel;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    n = 0;
    while (!cmd_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("cmd_accept", {63'h0, cmd_ready_o}, 64'h1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < limit) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic consumeResponse;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    checkOutput("rsp_drop", {63'h0, rsp_valid_o}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0;
    cmd_dat_i = '0; cmd_sel_i = '0; rsp_ready_i = 1'b0;
    stall_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    mon_adr = '0; mon_dat = '0; mon_sel = '0;
    stb_cnt = 0; cyc_cnt = 0; unstable_cnt = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_outputs",
                {cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_tmo_o, cyc_o, stb_o, we_o,
                 sel_o, rsp_dat_o}, 64'h0);
    checkOutput("reset_bus", {adr_o, dat_o}, 64'h0);
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ready_after_reset", {63'h0, cmd_ready_o}, 64'h1);

    // write, no stall, ack the cycle after stb
    resp_mode = 0; rd_data = 32'hCAFE_F00D;
    applyStimulus(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 50, lat);
    checkOutput("wr_latency", 64'(lat), 64'd3);
    checkOutput("wr_stb_cycles", 64'(stb_cnt), 64'd1);
    checkOutput("wr_cyc_cycles", 64'(cyc_cnt), 64'd2);
    checkOutput("wr_req_stable", 64'(unstable_cnt), 64'd0);
    checkOutput("wr_rsp", {31'h0, rsp_err_o, rsp_dat_o}, 64'h0);
    checkOutput("wr_cyc_drop", {62'h0, cyc_o, cmd_ready_o}, 64'h0);
    checkOutput("wr_fields_held", {43'h0, we_o, sel_o, adr_o}, {43'h0, 1'b1, 4'hF, 16'h0010});
    consumeResponse();

    // read with data
    rd_data = 32'h1234_5678;
    applyStimulus(1'b0, 16'h0004, 32'hFFFF_FFFF, 4'hF, 50, lat);
    checkOutput("rd_latency", 64'(lat), 64'd3);
    checkOutput("rd_req_stable", 64'(unstable_cnt), 64'd0);
    checkOutput("rd_dat", {32'h0, rsp_dat_o}, 64'h1234_5678);
    checkOutput("rd_err", {62'h0, rsp_err_o, rsp_tmo_o}, 64'h0);
    checkOutput("rd_we_dat", {31'h0, we_o, dat_o}, 64'h0);
    consumeResponse();

    // five stall cycles on the request
    stall_left = 5; rd_data = 32'h0BAD_F00D;
    applyStimulus(1'b0, 16'h0020, 32'h0, 4'h3, 50, lat);
    checkOutput("stall_stb_cycles", 64'(stb_cnt), 64'd6);
    checkOutput("stall_req_stable", 64'(unstable_cnt), 64'd0);
    checkOutput("stall_latency", 64'(lat), 64'd8);
    checkOutput("stall_rd_dat", {32'h0, rsp_dat_o}, 64'h0BAD_F00D);
    consumeResponse();

    // err_i alone, then ack_i and err_i together
    resp_mode = 1; rd_data = 32'h5555_AAAA;
    applyStimulus(1'b0, 16'h0040, 32'h0, 4'hF, 50, lat);
    checkOutput("err_latency", 64'(lat), 64'd3);
    checkOutput("err_rsp", {30'h0, rsp_err_o, rsp_tmo_o, rsp_dat_o}, {30'h0, 2'b10, 32'h0});
    checkOutput("err_cyc_drop", {63'h0, cyc_o}, 64'h0);
    consumeResponse();
    resp_mode = 2;
    applyStimulus(1'b0, 16'h0044, 32'h0, 4'hF, 50, lat);
    checkOutput("ackerr_rsp", {30'h0, rsp_err_o, rsp_tmo_o, rsp_dat_o}, {30'h0, 2'b10, 32'h0});
    checkOutput("ackerr_cyc_drop", {63'h0, cyc_o}, 64'h0);
    consumeResponse();

    // response back-pressure while a new command waits
    resp_mode = 0;
    applyStimulus(1'b1, 16'h0030, 32'hA5A5_5A5A, 4'h1, 50, lat);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 16'h0099; cmd_dat_i = 32'h1; cmd_sel_i = 4'h8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checkOutput("bp_hold", {60'h0, rsp_valid_o, rsp_err_o, cmd_ready_o, cyc_o}, {60'h0, 4'b1000});
    end
    cmd_valid_i = 1'b0;
    consumeResponse();
    checkOutput("bp_no_accept", {32'h0, sel_o, 12'h0, adr_o}, {32'h0, 4'h1, 12'h0, 16'h0030});

    // ack/err with no cycle open must be ignored
    stray_ack = 1'b1;
    repeat (3) @(negedge clk_i);
    stray_ack = 1'b0;
    checkOutput("stray_ack", {61'h0, rsp_valid_o, cyc_o, cmd_ready_o}, 64'h1);
    @(negedge clk_i);

`ifdef WB_TIMEOUT_EN
    resp_mode = 3;
    applyStimulus(1'b0, 16'h0050, 32'h0, 4'hF, 50, lat);
    checkOutput("tmo_latency", 64'(lat), 64'd9);
    checkOutput("tmo_cyc_cycles", 64'(cyc_cnt), 64'd8);
    checkOutput("tmo_rsp", {30'h0, rsp_err_o, rsp_tmo_o, rsp_dat_o}, {30'h0, 2'b11, 32'h0});
    checkOutput("tmo_bus_drop", {62'h0, cyc_o, stb_o}, 64'h0);
    consumeResponse();
    applyStimulus(1'b0, 16'h0060, 32'h0, 4'hF, 4, lat);
`else
    resp_mode = 3;
    applyStimulus(1'b0, 16'h0060, 32'h0, 4'hF, 300, lat);
`endif
    checkOutput("hang_waiting", {61'h0, rsp_valid_o, cyc_o, rsp_tmo_o}, 64'h2);

    // reset while waiting for the slave
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("midreset_outputs",
                {cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_tmo_o, cyc_o, stb_o, we_o,
                 sel_o, rsp_dat_o}, 64'h0);
    checkOutput("midreset_bus", {adr_o, dat_o}, 64'h0);
    @(negedge clk_i); rst_i = 1'b0; resp_mode = 0;
    repeat (2) @(negedge clk_i);
    checkOutput("ready_after_midreset", {62'h0, cmd_ready_o, rsp_valid_o}, 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
